// File: rtl/conv_axi_pkg.sv
// Shared constants and helpers for the convolution AXI4-Lite register slice.
package conv_axi_pkg;

    localparam int C_DATA_W   = 32;
    localparam int C_NUM_REGS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_OFS   = 'h00;
    localparam int CFG0_OFS   = 'h04;
    localparam int CFG1_OFS   = 'h08;
    localparam int CFG2_OFS   = 'h0C;
    localparam int STATUS_OFS = 'h10;

    // Merge the enabled byte lanes of data into old.
    function automatic logic [C_DATA_W-1:0] apply_wstrb(
        input logic [C_DATA_W-1:0]   old,
        input logic [C_DATA_W-1:0]   data,
        input logic [C_DATA_W/8-1:0] strb
    );
        logic [C_DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < C_DATA_W/8; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_axil_skid1.sv
// One-entry valid/ready holding buffer. Accepts a beat when empty and enabled,
// holds it until the consumer pops it; reopens the cycle after the pop.
module conv_axil_skid1 #(
    parameter int W = 32
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         full,
    output logic [W-1:0] out_data,
    input  logic         pop
);

    assign in_ready = en && !full;

    // Capture on handshake, release on pop (never both: pop needs full, push needs empty).
    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            full     <= 1'b0;
            out_data <= '0;
        end else if (in_valid && in_ready) begin
            full     <= 1'b1;
            out_data <= in_data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_axil_slave_regs.sv
// AXI4-Lite register file in front of the convolution core.
// Optional status register at word NUM_REGS when CONV_AXI_STATUS_REG_EN is defined.
module conv_axil_slave_regs
    import conv_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = C_NUM_REGS
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o,
    input  logic                            busy_i,
    input  logic                            done_i
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic                              rdy_en;
    logic                              aw_full, w_full, commit, w_map;
    logic [IDX_W-1:0]                  w_idx, ar_idx;
    logic [C_DATA_W-1:0]               w_data, rd_data;
    logic [STRB_W-1:0]                 w_strb;
    logic [1:0]                        rd_resp;
    logic [NUM_REGS-1:0][C_DATA_W-1:0] regs;

    // Readies stay low during reset and rise on the first cycle after release.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) rdy_en <= 1'b0;
        else                rdy_en <= 1'b1;
    end

    conv_axil_skid1 #(.W(IDX_W)) u_aw (
        .gclk     (S_AXI_ACLK),
        .grst_n   (S_AXI_ARESETN),
        .en       (rdy_en),
        .in_valid (S_AXI_AWVALID),
        .in_ready (S_AXI_AWREADY),
        .in_data  (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .full     (aw_full),
        .out_data (w_idx),
        .pop      (commit)
    );

    conv_axil_skid1 #(.W(C_DATA_W + STRB_W)) u_w (
        .gclk     (S_AXI_ACLK),
        .grst_n   (S_AXI_ARESETN),
        .en       (rdy_en),
        .in_valid (S_AXI_WVALID),
        .in_ready (S_AXI_WREADY),
        .in_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .full     (w_full),
        .out_data ({w_strb, w_data}),
        .pop      (commit)
    );

    // A write commits once both halves are buffered and the B slot is free.
    assign commit = aw_full && w_full && !S_AXI_BVALID;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign reg_o  = regs;

`ifdef CONV_AXI_STATUS_REG_EN
    localparam int STAT_IDX = STATUS_OFS / 4;
    logic done_sticky;

    assign w_map = int'(w_idx) <= STAT_IDX;

    // Sticky done flag; a new done beats a simultaneous W1C clear.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
            done_sticky <= 1'b0;
        else if (done_i)
            done_sticky <= 1'b1;
        else if (commit && int'(w_idx) == STAT_IDX && w_strb[0] && w_data[1])
            done_sticky <= 1'b0;
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign w_map = int'(w_idx) < NUM_REGS;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         busy_i, done_i};
`endif

    // Register array update and per-register write pulse, both on the commit edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            regs       <= '0;
            wr_pulse_o <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                wr_pulse_o[k] <= commit && (w_idx == IDX_W'(k));
                if (commit && (w_idx == IDX_W'(k)))
                    regs[k] <= apply_wstrb(regs[k], w_data, w_strb);
            end
        end
    end

    // Write response: one outstanding, held until BREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= w_map ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // Read decode; unmapped words return zero with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_data = regs[k];
                rd_resp = RESP_OKAY;
            end
        end
`ifdef CONV_AXI_STATUS_REG_EN
        if (int'(ar_idx) == STAT_IDX) begin
            rd_data = {{(C_DATA_W-2){1'b0}}, done_sticky, busy_i};
            rd_resp = RESP_OKAY;
        end
`endif
    end

    assign S_AXI_ARREADY = rdy_en && !S_AXI_RVALID;

    // Read response is registered on the AR handshake and held until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data;
            S_AXI_RRESP  <= rd_resp;
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_axil_slave_regs.sv
// Scoreboard bench for conv_axil_slave_regs: stimulus pushes expected B/R
// responses into queues, a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_conv_axil_slave_regs;

    localparam int AW = 5;
    localparam int NR = 4;
`ifdef CONV_AXI_STATUS_REG_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]      awprot = '0, arprot = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic            bready = 1'b1, rready = 1'b1;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            awready, wready, arready, bvalid, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;
    logic [NR*32-1:0] reg_o;
    logic [NR-1:0]   wr_pulse;
    logic            busy_i = 1'b0, done_i = 1'b0;

    always #5 clk = ~clk;

    conv_axil_slave_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_o(reg_o), .wr_pulse_o(wr_pulse), .busy_i(busy_i), .done_i(done_i)
    );

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

    int          tests = 0, fails = 0;
    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] model[NR];
    logic        m_done = 1'b0;
    int          exp_pulse[NR];
    int          pulse_cnt[NR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] model_pack();
        logic [NR*32-1:0] p;
        for (int k = 0; k < NR; k++) p[32*k +: 32] = model[k];
        return p;
    endfunction

    // Reference: words 0..NR-1 are plain byte-writable storage, status word optional, rest error.
    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            exp_pulse[idx]++;
            exp_b.push_back(2'b00);
        end else if (STATUS && idx == NR) begin
            if (s[0] && d[1]) m_done = 1'b0;
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endfunction

    function automatic void model_read(input logic [AW-1:0] a);
        int idx;
        idx = int'(a) / 4;
        if (idx < NR)                    exp_r.push_back({model[idx], 2'b00});
        else if (STATUS && idx == NR)    exp_r.push_back({30'b0, m_done, busy_i, 2'b00});
        else                             exp_r.push_back({32'h0, 2'b10});
    endfunction

    // Monitor: compares responses at each handshake and counts pulse cycles.
    always @(negedge clk) begin
        if (rstn && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected: got bresp %0h with empty queue", bresp);
            end else check("bresp", bresp, exp_b.pop_front());
        end
        if (rstn && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                tests++; fails++;
                $display("FAIL r_unexpected: got rdata %0h with empty queue", rdata);
            end else check("rdata_rresp", {rdata, rresp}, exp_r.pop_front());
        end
        for (int k = 0; k < NR; k++) if (wr_pulse[k]) pulse_cnt[k]++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic timeout(input string name);
        tests++; fails++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        bit hs;
        repeat (dly) tick();
        awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); hs = awready;
            tick();
            if (hs) begin awvalid = 1'b0; return; end
        end
        awvalid = 1'b0; timeout("aw_hs");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit hs;
        repeat (dly) tick();
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); hs = wready;
            tick();
            if (hs) begin wvalid = 1'b0; return; end
        end
        wvalid = 1'b0; timeout("w_hs");
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input int dly);
        bit hs;
        repeat (dly) tick();
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); hs = arready;
            tick();
            if (hs) begin arvalid = 1'b0; return; end
        end
        arvalid = 1'b0; timeout("ar_hs");
    endtask

    task automatic wait_b();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = bvalid && bready;
            tick();
        end
        if (!ok) timeout("b_hs");
    endtask

    task automatic wait_r();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = rvalid && rready;
            tick();
        end
        if (!ok) timeout("r_hs");
    endtask

    // Full write: both channels, then BVALID must appear exactly one edge after the later handshake.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        model_write(a, d, s);
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        check("b_lat_pre", bvalid, 1'b0);
        tick();
        check("b_lat_post", bvalid, 1'b1);
        wait_b();
        check("reg_o", reg_o, model_pack());
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int dly);
        model_read(a);
        send_ar(a, dly);
        check("r_lat", rvalid, 1'b1);
        wait_r();
    endtask

    initial begin
        logic [31:0] snap;
        logic [1:0]  snap_r;
        for (int k = 0; k < NR; k++) begin model[k] = '0; exp_pulse[k] = 0; pulse_cnt[k] = 0; end

        // Reset state
        repeat (3) tick();
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_valids", {bvalid, rvalid, wr_pulse}, '0);
        check("rst_data", {reg_o, rdata, bresp, rresp}, '0);
        rstn = 1'b1;
        tick();
        check("post_rst_readies", {awready, wready, arready}, 3'b111);

        // Basic writes and readback
        for (int k = 0; k < NR; k++) do_write(5'(4*k), 32'(k+1), 4'hF, 0, 0);
        for (int k = 0; k < NR; k++) do_read(5'(4*k), 0);

        // Skewed channels
        do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0);
        do_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3);
        check("reg2_deadbeef", reg_o[95:64], 32'hDEADBEEF);

        // Byte strobes
        do_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_write(5'h04, 32'h12345678, 4'b0101, 0, 0);
        check("reg1_strb", reg_o[63:32], 32'hFF34FF78);
        do_write(5'h04, 32'h0, 4'h0, 1, 0);

        // Unmapped
        do_write(5'h18, 32'hCAFEF00D, 4'hF, 0, 0);
        do_read(5'h18, 0);

        // B backpressure with a second beat buffered behind it
        bready = 1'b0;
        model_write(5'h0C, 32'hA5A5A5A5, 4'hF);
        fork send_aw(5'h0C, 0); send_w(32'hA5A5A5A5, 4'hF, 0); join
        tick();
        model_write(5'h00, 32'h0BADF00D, 4'hF);
        fork send_aw(5'h00, 0); send_w(32'h0BADF00D, 4'hF, 0); join
        snap_r = bresp;
        for (int i = 0; i < 5; i++) begin
            check("b_stall_valid", {bvalid, bresp}, {1'b1, snap_r});
            check("b_stall_readies", {awready, wready}, 2'b00);
            tick();
        end
        bready = 1'b1;
        wait_b();
        wait_b();
        check("reg_o_after_stall", reg_o, model_pack());

        // R backpressure
        rready = 1'b0;
        model_read(5'h0C);
        send_ar(5'h0C, 0);
        snap = rdata;
        for (int i = 0; i < 5; i++) begin
            check("r_stall", {rvalid, arready, rdata}, {1'b1, 1'b0, snap});
            tick();
        end
        rready = 1'b1;
        wait_r();
        check("arready_after_r", arready, 1'b1);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            a = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2));
        end
        do_read(5'h10, 0);

        for (int k = 0; k < NR; k++) check("pulse_cnt", pulse_cnt[k], exp_pulse[k]);

`ifdef CONV_AXI_STATUS_REG_EN
        done_i = 1'b1; tick(); done_i = 1'b0; m_done = 1'b1;
        do_read(5'h10, 0);
        do_write(5'h10, 32'h2, 4'h1, 0, 0);
        do_read(5'h10, 0);
`endif

        // Reset while a response is pending
        bready = 1'b0;
        model_write(5'h00, 32'h55AA55AA, 4'hF);
        fork send_aw(5'h00, 0); send_w(32'h55AA55AA, 4'hF, 0); join
        tick();
        check("pre_rst_bvalid", bvalid, 1'b1);
        rstn = 1'b0;
        tick();
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_reg_o", reg_o, '0);
        rstn = 1'b1;
        exp_b.delete();
        for (int k = 0; k < NR; k++) model[k] = '0;
        m_done = 1'b0;
        bready = 1'b1;
        tick();
        check("rearm_readies", {awready, wready, arready}, 3'b111);
        do_read(5'h08, 0);

        check("queues_drained", exp_b.size() + exp_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
